// File: rtl/fft_stage_sequencer_if.sv
// Handshake bundle between the FFT controller and the stage sequencer.
// master drives start/size/ready; slave (the sequencer) returns status and butterfly descriptors.
interface fft_stage_sequencer_if #(
  parameter int MAX_N       = 32,
  parameter int ADDR_WIDTH  = $clog2(MAX_N),
  parameter int STAGE_WIDTH = $clog2($clog2(MAX_N))
);
  logic                   start;
  logic [ADDR_WIDTH:0]    n_points;
  logic                   busy;
  logic                   done;
  logic                   err;
  logic                   bf_valid;
  logic                   bf_ready;
  logic [ADDR_WIDTH-1:0]  addr_a;
  logic [ADDR_WIDTH-1:0]  addr_b;
  logic [ADDR_WIDTH-1:0]  tw_k;
  logic [ADDR_WIDTH:0]    tw_n;
  logic [STAGE_WIDTH-1:0] stage;
  logic                   last_bf;

  modport master (
    output start, n_points, bf_ready,
    input  busy, done, err, bf_valid, addr_a, addr_b, tw_k, tw_n, stage, last_bf
  );

  modport slave (
    input  start, n_points, bf_ready,
    output busy, done, err, bf_valid, addr_a, addr_b, tw_k, tw_n, stage, last_bf
  );
endinterface

// File: rtl/fft_stage_sequencer.sv
// Radix-2 DIT FFT address/twiddle sequencer: one butterfly per cycle, PIPE_LAT drain between stages.
// Descriptors hold while bf_ready is low; done follows log2N*(N/2+PIPE_LAT)+1 cycles after start.
module fft_stage_sequencer #(
  parameter int MAX_N       = 32,
  parameter int ADDR_WIDTH  = $clog2(MAX_N),
  parameter int STAGE_WIDTH = $clog2($clog2(MAX_N)),
  parameter int PIPE_LAT    = 2
) (
  input logic clk,
  input logic rst,
  fft_stage_sequencer_if.slave bus
);
  localparam int CNT_WIDTH   = ADDR_WIDTH - 1;
  localparam int DRAIN_WIDTH = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [CNT_WIDTH-1:0]   bf_cnt;
  logic [CNT_WIDTH-1:0]   last_cnt;
  logic [STAGE_WIDTH-1:0] stage_q;
  logic [STAGE_WIDTH-1:0] last_stage;
  logic [DRAIN_WIDTH-1:0] drain_cnt;
  logic                   err_q;

  logic                   n_legal;
  logic [STAGE_WIDTH-1:0] n_last_stage;
  logic [CNT_WIDTH-1:0]   n_last_cnt;
  logic                   is_last;

  logic [ADDR_WIDTH-1:0]  half;
  logic [ADDR_WIDTH-1:0]  low_mask;
  logic [ADDR_WIDTH-1:0]  cnt_ext;
  logic [ADDR_WIDTH-1:0]  addr_a_c;

  // Size decode: legal sizes are the powers of two from 2 up to MAX_N.
  always_comb begin
    n_legal      = 1'b0;
    n_last_stage = '0;
    for (int i = 1; i <= ADDR_WIDTH; i++) begin
      if (bus.n_points == ((ADDR_WIDTH+1)'(1) << i)) begin
        n_legal      = 1'b1;
        n_last_stage = STAGE_WIDTH'(i - 1);
      end
    end
    // N/2-1 in counter width; for N=MAX_N the low bits wrap to all ones.
    n_last_cnt = bus.n_points[CNT_WIDTH:1] - CNT_WIDTH'(1);
  end

  // Operand addresses: insert a zero bit at position 'stage' into bf_cnt.
  always_comb begin
    half     = ADDR_WIDTH'(1) << stage_q;
    low_mask = half - ADDR_WIDTH'(1);
    cnt_ext  = {1'b0, bf_cnt};
    addr_a_c = ((cnt_ext & ~low_mask) << 1) | (cnt_ext & low_mask);
    is_last  = (bf_cnt == last_cnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (bus.start && n_legal) state_nxt = ISSUE;
      ISSUE:  if (bus.bf_ready && is_last) state_nxt = DRAIN;
      DRAIN:  if (drain_cnt == '0) state_nxt = (stage_q == last_stage) ? FINISH : ISSUE;
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bf_cnt     <= '0;
      last_cnt   <= '0;
      stage_q    <= '0;
      last_stage <= '0;
      drain_cnt  <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (n_legal) begin
              bf_cnt     <= '0;
              stage_q    <= '0;
              last_stage <= n_last_stage;
              last_cnt   <= n_last_cnt;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (bus.bf_ready) begin
            if (is_last) begin
              drain_cnt <= DRAIN_WIDTH'(PIPE_LAT - 1);
            end else begin
              bf_cnt <= bf_cnt + CNT_WIDTH'(1);
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            if (stage_q != last_stage) begin
              stage_q <= stage_q + STAGE_WIDTH'(1);
              bf_cnt  <= '0;
            end
          end else begin
            drain_cnt <= drain_cnt - DRAIN_WIDTH'(1);
          end
        end
        FINISH: begin
          stage_q <= '0;
          bf_cnt  <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy     = (state == ISSUE) || (state == DRAIN);
    bus.done     = (state == FINISH);
    bus.err      = err_q;
    bus.stage    = stage_q;
    bus.bf_valid = 1'b0;
    bus.addr_a   = '0;
    bus.addr_b   = '0;
    bus.tw_k     = '0;
    bus.tw_n     = '0;
    bus.last_bf  = 1'b0;
    if (state == ISSUE) begin
      bus.bf_valid = 1'b1;
      bus.addr_a   = addr_a_c;
      bus.addr_b   = addr_a_c | half;
      bus.tw_k     = cnt_ext & low_mask;
      bus.tw_n     = {half, 1'b0};
      bus.last_bf  = is_last;
    end
  end
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: descriptor streams are compared against an arithmetic
// model of the radix-2 DIT butterfly order, under fixed, toggling and random bf_ready.
`timescale 1ns/1ps
module tb_fft_stage_sequencer;
  localparam int MAX_N    = 32;
  localparam int PIPE_LAT = 2;
  localparam int AW       = 5;
  localparam int SW       = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_stage_sequencer_if #(.MAX_N(MAX_N)) bus();
  fft_stage_sequencer #(.MAX_N(MAX_N), .PIPE_LAT(PIPE_LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int fails  = 0;

  typedef struct {
    int a;
    int b;
    int k;
    int n;
    int s;
    bit last;
  } desc_t;

  desc_t exp_q[$];

  function automatic int ilog2(input int n);
    int l = 0;
    while ((1 << l) < n) l++;
    return l;
  endfunction

  // Butterfly j of stage s pairs elements separated by half = 2^s inside groups of 2*half.
  task automatic build_model(input int n);
    int half;
    desc_t d;
    exp_q.delete();
    for (int s = 0; s < ilog2(n); s++) begin
      half = 1 << s;
      for (int j = 0; j < n / 2; j++) begin
        d.a    = (j / half) * 2 * half + (j % half);
        d.b    = d.a + half;
        d.k    = j % half;
        d.n    = 2 * half;
        d.s    = s;
        d.last = (j == n / 2 - 1);
        exp_q.push_back(d);
      end
    end
  endtask

  // mode: 0 ready high, 1 ready toggling, 2 random ready. poke_at>0 issues a start mid-run.
  task automatic run_fft(input int n, input int mode, input int poke_at,
                         output int done_cyc, output int xfers, output int gaps);
    desc_t e;
    int cyc = 0;
    bit was_stalled = 0;
    build_model(n);
    done_cyc = -1;
    xfers    = 0;
    gaps     = 0;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.n_points = (AW+1)'(n);
    bus.bf_ready = 1'b1;
    while (cyc < 4000) begin
      @(negedge clk);
      cyc++;
      bus.start    = (cyc == poke_at);
      bus.n_points = (cyc == poke_at) ? (AW+1)'(4) : (AW+1)'(n);
      case (mode)
        0:       bus.bf_ready = 1'b1;
        1:       bus.bf_ready = (cyc % 2 == 1);
        default: bus.bf_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (bus.done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      checks++;
      if (bus.busy !== 1'b1) begin
        fails++;
        $display("FAIL busy_during_run N=%0d cyc=%0d: busy=%b, required 1", n, cyc, bus.busy);
      end
      if (was_stalled) begin
        checks++;
        if (bus.bf_valid !== 1'b1) begin
          fails++;
          $display("FAIL hold_valid N=%0d cyc=%0d: bf_valid=%b after stall, required 1", n, cyc, bus.bf_valid);
        end
      end
      was_stalled = 0;
      if (bus.bf_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL extra_descriptor N=%0d cyc=%0d: bf_valid=1 with no butterfly left", n, cyc);
        end else begin
          e = exp_q[0];
          if (bus.addr_a !== AW'(e.a) || bus.addr_b !== AW'(e.b) || bus.tw_k !== AW'(e.k) ||
              bus.tw_n !== (AW+1)'(e.n) || bus.stage !== SW'(e.s) || bus.last_bf !== e.last) begin
            fails++;
            $display("FAIL descriptor N=%0d cyc=%0d: got a=%0d b=%0d k=%0d n=%0d s=%0d last=%b, required a=%0d b=%0d k=%0d n=%0d s=%0d last=%b",
                     n, cyc, bus.addr_a, bus.addr_b, bus.tw_k, bus.tw_n, bus.stage, bus.last_bf,
                     e.a, e.b, e.k, e.n, e.s, e.last);
          end
          if (bus.bf_ready) begin
            void'(exp_q.pop_front());
            xfers++;
          end else begin
            was_stalled = 1;
          end
        end
      end else begin
        gaps++;
      end
    end
    checks++;
    if (done_cyc < 0) begin
      fails++;
      $display("FAIL done_timeout N=%0d: no done within %0d cycles", n, cyc);
    end
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL missing_descriptors N=%0d: %0d left, required 0", n, exp_q.size());
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.bf_valid !== 1'b0) begin
      fails++;
      $display("FAIL done_cycle N=%0d: busy=%b bf_valid=%b, required 0 0", n, bus.busy, bus.bf_valid);
    end
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.stage !== '0 || bus.tw_n !== '0) begin
      fails++;
      $display("FAIL after_done N=%0d: done=%b busy=%b stage=%0d tw_n=%0d, required 0 0 0 0",
               n, bus.done, bus.busy, bus.stage, bus.tw_n);
    end
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.start    = 1'b1;
    bus.n_points = (AW+1)'(4);
    bus.bf_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.err, bus.bf_valid, bus.addr_a, bus.addr_b, bus.tw_k,
         bus.tw_n, bus.stage, bus.last_bf} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: busy=%b done=%b err=%b valid=%b a=%0d b=%0d k=%0d n=%0d s=%0d last=%b, required all 0",
               bus.busy, bus.done, bus.err, bus.bf_valid, bus.addr_a, bus.addr_b, bus.tw_k,
               bus.tw_n, bus.stage, bus.last_bf);
    end
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_start_ignored: busy=%b, required 0", bus.busy);
    end
  endtask

  task automatic test_fixed(input int n, input int mode, input int want_done);
    int dc, xf, gp;
    run_fft(n, mode, 0, dc, xf, gp);
    checks++;
    if (xf != (n / 2) * ilog2(n)) begin
      fails++;
      $display("FAIL transfers N=%0d: %0d, required %0d", n, xf, (n / 2) * ilog2(n));
    end
    checks++;
    if (gp != ilog2(n) * PIPE_LAT) begin
      fails++;
      $display("FAIL drain_gaps N=%0d: %0d idle busy cycles, required %0d", n, gp, ilog2(n) * PIPE_LAT);
    end
    if (want_done > 0) begin
      checks++;
      if (dc != want_done) begin
        fails++;
        $display("FAIL latency N=%0d: done at cycle %0d, required %0d", n, dc, want_done);
      end
    end
  endtask

  task automatic test_err();
    int bad[5] = '{12, 0, 1, 63, 6};
    foreach (bad[i]) begin
      @(negedge clk);
      bus.start    = 1'b1;
      bus.n_points = (AW+1)'(bad[i]);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      checks++;
      if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.bf_valid !== 1'b0) begin
        fails++;
        $display("FAIL err_pulse n=%0d: err=%b busy=%b valid=%b, required 1 0 0", bad[i], bus.err, bus.busy, bus.bf_valid);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.err !== 1'b0 || bus.busy !== 1'b0 || bus.bf_valid !== 1'b0) begin
        fails++;
        $display("FAIL err_once n=%0d: err=%b busy=%b valid=%b, required 0 0 0", bad[i], bus.err, bus.busy, bus.bf_valid);
      end
    end
  endtask

  task automatic test_busy_start();
    int dc, xf, gp;
    run_fft(8, 0, 5, dc, xf, gp);
    checks++;
    if (xf != 12 || dc != 19) begin
      fails++;
      $display("FAIL busy_start: transfers=%0d done_cyc=%0d, required 12 19", xf, dc);
    end
  endtask

  task automatic test_random();
    int dc, xf, gp, n;
    for (int it = 0; it < 8; it++) begin
      n = 1 << $urandom_range(1, 5);
      run_fft(n, 2, 0, dc, xf, gp);
      checks++;
      if (xf != (n / 2) * ilog2(n) || gp != ilog2(n) * PIPE_LAT) begin
        fails++;
        $display("FAIL random N=%0d: transfers=%0d gaps=%0d, required %0d %0d",
                 n, xf, gp, (n / 2) * ilog2(n), ilog2(n) * PIPE_LAT);
      end
    end
  endtask

  task automatic test_mid_reset();
    int wait_cyc = 0;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.n_points = (AW+1)'(16);
    bus.bf_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (!(bus.stage === SW'(1) && bus.bf_valid === 1'b1) && wait_cyc < 200) begin
      @(negedge clk);
      wait_cyc++;
    end
    checks++;
    if (wait_cyc >= 200) begin
      fails++;
      $display("FAIL mid_reset_reach: stage 1 never presented, stage=%0d", bus.stage);
    end
    @(negedge clk);
    rst          = 1'b1;
    bus.start    = 1'b1;
    bus.n_points = (AW+1)'(8);
    @(posedge clk);
    #1;
    checks++;
    if (bus.bf_valid !== 1'b0 || bus.busy !== 1'b0 || bus.stage !== '0 || bus.done !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: valid=%b busy=%b stage=%0d done=%b, required 0 0 0 0",
               bus.bf_valid, bus.busy, bus.stage, bus.done);
    end
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      fails++;
      $display("FAIL reset_wins_start: busy=%b done=%b, required 0 0", bus.busy, bus.done);
    end
    test_fixed(4, 0, 9);
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.n_points = '0;
    bus.bf_ready = 1'b0;
    test_reset();
    test_fixed(4, 0, 9);
    test_fixed(2, 0, 4);
    test_fixed(8, 1, 0);
    test_fixed(32, 0, 91);
    test_err();
    test_busy_start();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
